// File: rtl/input_port_unit_if.sv
// rtl/input_port_unit_if.sv - upstream flit and allocator request signals of one router input port
interface input_port_unit_if #(
  parameter int FLIT_W = 32
);
  logic              in_valid;
  logic [FLIT_W-1:0] in_flit;
  logic              in_ready;
  logic [2:0]        port_dst;
  logic              port_en;
  logic              grant;
  logic [FLIT_W-1:0] out_flit;

  modport master (
    output in_valid, in_flit, grant,
    input  in_ready, port_dst, port_en, out_flit
  );

  modport slave (
    input  in_valid, in_flit, grant,
    output in_ready, port_dst, port_en, out_flit
  );
endinterface

// File: rtl/input_port_unit.sv
// rtl/input_port_unit.sv - router input FIFO with XY route latch and allocator request
// INPUT_PORT_ERR_CNT_EN builds the saturating malformed-flit counter; otherwise err_cnt is 0.
module input_port_unit #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4,
  parameter int X_ID   = 0,
  parameter int Y_ID   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input_port_unit_if.slave    bus,
  output logic [7:0]          err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [2:0] OUT_LOCAL_PORT = 3'd0;
  localparam logic [2:0] OUT_X1_PORT    = 3'd1;
  localparam logic [2:0] OUT_X2_PORT    = 3'd2;
  localparam logic [2:0] OUT_Y1_PORT    = 3'd3;

  typedef enum logic {IDLE, ROUTED} state_t;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [AW:0]       count;
  state_t            state, state_n;
  logic [2:0]        port_dst_r;
  logic              latch_route, drop, push, pop, empty, ready, req;
  logic [1:0]        head_type;

  function automatic logic [2:0] xy_route(input logic [2:0] dst);
    logic [1:0] dx;
    logic       dy;
    dx = dst[1:0];
    dy = dst[2];
    if (dx < 2'(X_ID))      return OUT_X1_PORT;
    else if (dx > 2'(X_ID)) return OUT_X2_PORT;
    else if (dy != 1'(Y_ID)) return OUT_Y1_PORT;
    else                    return OUT_LOCAL_PORT;
  endfunction

  assign empty     = (count == '0);
  assign ready     = (count != FULL);
  assign req       = (state == ROUTED) && !empty;
  assign head_type = mem[rd_ptr][FLIT_W-1 -: 2];
  assign push      = bus.in_valid && ready;
  assign pop       = (bus.grant && req) || drop;

  assign bus.in_ready = ready;
  assign bus.port_en  = req;
  assign bus.port_dst = port_dst_r;
  assign bus.out_flit = mem[rd_ptr];

  // Type bit 1 marks a packet start (head/single), bit 0 a packet end (tail/single).
  always_comb begin
    state_n     = state;
    latch_route = 1'b0;
    drop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (head_type[1]) begin
            latch_route = 1'b1;
            state_n     = ROUTED;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ROUTED: begin
        if (bus.grant && !empty && head_type[0]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      port_dst_r <= OUT_LOCAL_PORT;
    end else begin
      state <= state_n;
      if (latch_route) port_dst_r <= xy_route(mem[rd_ptr][2:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.in_flit;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef INPUT_PORT_ERR_CNT_EN
  logic [7:0] err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         err_q <= 8'd0;
    else if (drop && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end
  assign err_cnt = err_q;
`else
  assign err_cnt = 8'd0;
`endif
endmodule
